// File: rtl/alu_op_sequencer.sv
// Purpose: walks an 8-entry ALU op table through the ALU and holds each operand/result set for display.
// Latency: start -> alu_valid 1 clk; alu_done -> disp_* 1 clk; each entry then held DWELL_CYCLES clks.
// Backpressure: alu_valid and operands held stable until alu_ready; a missing alu_done is bounded by TIMEOUT_CYCLES.
module alu_op_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [3:0] cfg_x,
  input  logic [3:0] cfg_y,
  input  logic [3:0] cfg_m,
  input  logic       cfg_cin,
  input  logic [3:0] cfg_len,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic       abort,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [3:0] alu_m,
  output logic       alu_cin,
  output logic       alu_valid,
  input  logic       alu_ready,
  input  logic       alu_done,
  input  logic [3:0] alu_s,
  input  logic       alu_cout,
  output logic [3:0] disp_x,
  output logic [3:0] disp_y,
  output logic [3:0] disp_m,
  output logic [3:0] disp_s,
  output logic       disp_cout,
  output logic       disp_valid,
  output logic [2:0] cur_index,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DWELL, STEP_WAIT, DONE} state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] m;
    logic       cin;
  } entry_t;

  // Counters compare against the last count value so a state lasts exactly N clocks.
  localparam logic [26:0] DWELL_LAST   = 27'(DWELL_CYCLES - 1);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  entry_t      op_table [8];
  entry_t      cur_op;
  logic [2:0]  index;
  logic [2:0]  len_m1;
  logic        step_q;
  logic [26:0] dwell_cnt;
  logic [7:0]  to_cnt;

  logic        start_run;
  logic        is_last;
  logic        wait_end;
  logic        dwell_end;
  logic [2:0]  len_norm_m1;

  assign cur_op    = op_table[index];
  assign alu_x     = cur_op.x;
  assign alu_y     = cur_op.y;
  assign alu_m     = cur_op.m;
  assign alu_cin   = cur_op.cin;
  assign cur_index = index;

  // Decode run events; a length of 0 or above 8 runs the whole table.
  always_comb begin
    start_run   = (state == IDLE) && start;
    is_last     = (index == len_m1);
    wait_end    = (state == WAIT) && (alu_done || (to_cnt == TIMEOUT_LAST));
    dwell_end   = (state == DWELL) && (dwell_cnt == DWELL_LAST);
    len_norm_m1 = ((cfg_len == 4'd0) || (cfg_len > 4'd8)) ? 3'd7 : 3'(cfg_len - 4'd1);
  end

  // Next-state and FSM outputs; abort outranks every other event outside IDLE.
  always_comb begin
    state_next = state;
    alu_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        alu_valid = 1'b1;
        if (alu_ready) state_next = WAIT;
      end
      WAIT: begin
        if (wait_end) state_next = DWELL;
      end
      DWELL: begin
        if (dwell_end) begin
          if (step_q)       state_next = STEP_WAIT;
          else if (is_last) state_next = DONE;
          else              state_next = ISSUE;
        end
      end
      STEP_WAIT: begin
        if (step) state_next = is_last ? DONE : ISSUE;
      end
      DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Op table: host/switch writes land only while the sequencer is not running.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) op_table[i] <= '0;
    end else if (cfg_we && !busy) begin
      op_table[cfg_addr] <= {cfg_x, cfg_y, cfg_m, cfg_cin};
    end
  end

  // Run control: latch length/mode on start, advance index when moving on to the next issue.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      index  <= 3'd0;
      len_m1 <= 3'd0;
      step_q <= 1'b0;
    end else if (start_run) begin
      index  <= 3'd0;
      len_m1 <= len_norm_m1;
      step_q <= step_mode;
    end else if ((state_next == ISSUE) && (state != ISSUE) && (state != IDLE)) begin
      index  <= index + 3'd1;
    end
  end

  // Dwell and timeout counters restart on every state change and saturate inside a state.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
      to_cnt    <= '0;
    end else if (state_next != state) begin
      dwell_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      if ((state == DWELL) && (dwell_cnt != DWELL_LAST)) dwell_cnt <= dwell_cnt + 27'd1;
      if ((state == WAIT) && (to_cnt != TIMEOUT_LAST))   to_cnt    <= to_cnt + 8'd1;
    end
  end

  // Display capture: result on alu_done, zeros plus sticky error on timeout; operands shown either way.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      disp_x      <= 4'd0;
      disp_y      <= 4'd0;
      disp_m      <= 4'd0;
      disp_s      <= 4'd0;
      disp_cout   <= 1'b0;
      disp_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (start_run) begin
      disp_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      disp_valid  <= 1'b0;
    end else if (wait_end) begin
      disp_x     <= cur_op.x;
      disp_y     <= cur_op.y;
      disp_m     <= cur_op.m;
      disp_valid <= 1'b1;
      if (alu_done) begin
        disp_s    <= alu_s;
        disp_cout <= alu_cout;
      end else begin
        disp_s      <= 4'd0;
        disp_cout   <= 1'b0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed runs against a small ALU model.
// Expected transfers/results are queued at stimulus time; a negedge monitor pops and compares.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

  localparam int DWELL = 4;
  localparam int TMO   = 16;

  logic       clock_100Mhz = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_x, cfg_y, cfg_m;
  logic       cfg_cin;
  logic [3:0] cfg_len;
  logic       start, step_mode, step, abort;
  logic [3:0] alu_x, alu_y, alu_m;
  logic       alu_cin, alu_valid;
  logic       alu_ready, alu_done;
  logic [3:0] alu_s;
  logic       alu_cout;
  logic [3:0] disp_x, disp_y, disp_m, disp_s;
  logic       disp_cout, disp_valid;
  logic [2:0] cur_index;
  logic       busy, done, timeout_err;

  alu_op_sequencer #(.DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_m(cfg_m),
    .cfg_cin(cfg_cin), .cfg_len(cfg_len), .start(start), .step_mode(step_mode),
    .step(step), .abort(abort),
    .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_cin(alu_cin), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_done(alu_done), .alu_s(alu_s), .alu_cout(alu_cout),
    .disp_x(disp_x), .disp_y(disp_y), .disp_m(disp_m), .disp_s(disp_s),
    .disp_cout(disp_cout), .disp_valid(disp_valid), .cur_index(cur_index),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  typedef struct { logic [2:0] idx; logic [3:0] x, y, m; logic cin; } xfer_t;
  typedef struct { logic [3:0] s; logic cout; logic [3:0] x, y, m; logic to; logic err; } res_t;

  xfer_t exp_xfer[$];
  res_t  exp_res[$];

  int checks = 0;
  int errors = 0;
  int xfer_count = 0;
  int res_count = 0;
  int done_count = 0;
  int last_vrun = 0;
  int vrun = 0;
  int k = 0;
  bit pend = 0;
  bit prev_done = 0;

  // ALU model controls
  int         stall_left = 0;
  bit         drop_en = 0;
  logic [2:0] drop_idx = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU: add, subtract-with-carry, and, xor.
  function automatic logic [4:0] alu_fn(input logic [3:0] x, input logic [3:0] y,
                                        input logic [3:0] m, input logic cin);
    case (m)
      4'd0:    return {1'b0, x} + {1'b0, y} + {4'd0, cin};
      4'd1:    return {1'b0, x} + {1'b0, ~y} + {4'd0, cin};
      4'd2:    return {1'b0, x & y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  // ALU model: done two clocks after a transfer; optional stall and dropped done.
  initial begin : alu_model
    logic [3:0] ms;
    logic       mc;
    int         mdone;
    ms = 4'd0; mc = 1'b0; mdone = 0;
    alu_ready = 1'b1; alu_done = 1'b0; alu_s = 4'd0; alu_cout = 1'b0;
    forever begin
      @(negedge clock_100Mhz);
      if (!reset && alu_valid && alu_ready && !(drop_en && cur_index == drop_idx)) begin
        {mc, ms} = alu_fn(alu_x, alu_y, alu_m, alu_cin);
        mdone = 2;
      end
      @(posedge clock_100Mhz);
      #1;
      alu_done = 1'b0;
      if (reset) begin
        mdone = 0;
      end else if (mdone > 0) begin
        mdone--;
        if (mdone == 0) begin
          alu_done = 1'b1;
          alu_s    = ms;
          alu_cout = mc;
        end
      end
      if (alu_valid && stall_left > 0) begin
        alu_ready = 1'b0;
        stall_left--;
      end else begin
        alu_ready = 1'b1;
      end
    end
  end

  // Monitor: checks issued operands every valid cycle and each display capture.
  always @(negedge clock_100Mhz) begin
    if (reset) begin
      pend = 0; prev_done = 0; vrun = 0;
    end else begin
      if (done) done_count++;
      if (pend) begin
        k++;
        if (prev_done || k == TMO + 1) begin
          check("res_queue_nonempty", 32'(exp_res.size() != 0), 1);
          if (exp_res.size() != 0) begin
            check("res_path_timeout", 32'(!prev_done), 32'(exp_res[0].to));
            check("disp_s", 32'(disp_s), 32'(exp_res[0].s));
            check("disp_cout", 32'(disp_cout), 32'(exp_res[0].cout));
            check("disp_ops", 32'({disp_x, disp_y, disp_m}),
                  32'({exp_res[0].x, exp_res[0].y, exp_res[0].m}));
            check("disp_valid", 32'(disp_valid), 1);
            check("timeout_err", 32'(timeout_err), 32'(exp_res[0].err));
            void'(exp_res.pop_front());
          end
          res_count++;
          pend = 0;
        end else if (k == TMO && exp_res.size() != 0 && exp_res[0].to) begin
          check("timeout_not_early", 32'(timeout_err), 0);
        end
      end
      prev_done = alu_done;
      if (alu_valid) begin
        vrun++;
        check("xfer_queue_nonempty", 32'(exp_xfer.size() != 0), 1);
        if (exp_xfer.size() != 0) begin
          check("alu_operands", 32'({alu_x, alu_y, alu_m, alu_cin}),
                32'({exp_xfer[0].x, exp_xfer[0].y, exp_xfer[0].m, exp_xfer[0].cin}));
          if (alu_ready) begin
            check("xfer_index", 32'(cur_index), 32'(exp_xfer[0].idx));
            void'(exp_xfer.pop_front());
            xfer_count++;
            pend = 1;
            k = 0;
          end
        end
      end else if (vrun != 0) begin
        last_vrun = vrun;
        vrun = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int x, input int y, input int m, input int cin);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_x = 4'(x); cfg_y = 4'(y); cfg_m = 4'(m); cfg_cin = 1'(cin);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic push_op(input int idx, input int x, input int y, input int m, input int cin,
                         input int s, input int cout, input int to, input int err);
    xfer_t xe;
    res_t  re;
    xe.idx = 3'(idx); xe.x = 4'(x); xe.y = 4'(y); xe.m = 4'(m); xe.cin = 1'(cin);
    re.s = 4'(s); re.cout = 1'(cout); re.x = 4'(x); re.y = 4'(y); re.m = 4'(m);
    re.to = 1'(to); re.err = 1'(err);
    exp_xfer.push_back(xe);
    exp_res.push_back(re);
  endtask

  task automatic run_start(input int len, input bit sm);
    cfg_len = 4'(len); step_mode = sm; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  base;
    bit  seen;
    base = done_count;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = (done_count != base);
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic wait_res(input int target, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = (res_count >= target);
    end
    check("result_within_budget", 32'(seen), 1);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = (xfer_count >= target);
    end
    check("xfer_within_budget", 32'(seen), 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int bd, bx, br;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_x = 4'd0; cfg_y = 4'd0; cfg_m = 4'd0;
    cfg_cin = 1'b0; cfg_len = 4'd0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
    tick(3);
    check("rst_ctrl", 32'({alu_valid, busy, done, disp_valid, timeout_err}), 0);
    check("rst_index", 32'(cur_index), 0);
    check("rst_alu_ops", 32'({alu_x, alu_y, alu_m, alu_cin}), 0);
    check("rst_disp", 32'({disp_x, disp_y, disp_m, disp_s, disp_cout}), 0);
    reset = 1'b0;
    tick(2);

    // Basic three-entry run.
    cfg_write(0, 3, 4, 0, 0);
    cfg_write(1, 9, 8, 1, 1);
    cfg_write(2, 15, 1, 2, 0);
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    push_op(1, 9, 8, 1, 1, 1, 1, 0, 0);
    push_op(2, 15, 1, 2, 0, 1, 0, 0, 0);
    bd = done_count; bx = xfer_count;
    run_start(3, 0);
    wait_done("t1_done", 100);
    check("t1_busy_after_done", 32'(busy), 0);
    check("t1_done_single", 32'(done), 0);
    check("t1_xfers", 32'(xfer_count - bx), 3);
    check("t1_done_count", 32'(done_count - bd), 1);
    check("t1_disp_retained", 32'(disp_valid), 1);
    check("t1_queues_empty", 32'(exp_xfer.size() + exp_res.size()), 0);

    // Ready held low for five cycles on entry 0.
    stall_left = 5;
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    bx = xfer_count;
    run_start(1, 0);
    wait_done("t2_done", 60);
    check("t2_valid_cycles", 32'(last_vrun), 6);
    check("t2_xfers", 32'(xfer_count - bx), 1);

    // No alu_done on entry 1: timeout, run continues, error sticky.
    drop_en = 1; drop_idx = 3'd1;
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    push_op(1, 9, 8, 1, 1, 0, 0, 1, 1);
    push_op(2, 15, 1, 2, 0, 1, 0, 0, 1);
    bx = xfer_count;
    run_start(3, 0);
    wait_done("t3_done", 200);
    drop_en = 0;
    check("t3_xfers", 32'(xfer_count - bx), 3);
    tick(3);
    check("t3_err_sticky", 32'(timeout_err), 1);

    // Single-step mode, two entries.
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    push_op(1, 9, 8, 1, 1, 1, 1, 0, 0);
    bd = done_count; bx = xfer_count; br = res_count;
    run_start(2, 1);
    check("t4_err_cleared", 32'(timeout_err), 0);
    tick(40);
    check("t4_hold0_state", 32'({busy, alu_valid}), 32'(2'b10));
    check("t4_hold0_index", 32'(cur_index), 0);
    check("t4_hold0_progress", 32'({xfer_count - bx, res_count - br, done_count - bd}),
          32'({32'd1, 32'd1, 32'd0}));
    step = 1'b1; tick(1); step = 1'b0;
    tick(40);
    check("t4_hold1_index", 32'(cur_index), 1);
    check("t4_hold1_busy", 32'(busy), 1);
    check("t4_hold1_xfers", 32'(xfer_count - bx), 2);
    check("t4_hold1_nodone", 32'(done_count - bd), 0);
    step = 1'b1; tick(1); step = 1'b0;
    wait_done("t4_done", 10);
    check("t4_done_count", 32'(done_count - bd), 1);

    // Abort during dwell of entry 1; cfg write while busy is dropped.
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    push_op(1, 9, 8, 1, 1, 1, 1, 0, 0);
    bd = done_count; bx = xfer_count; br = res_count;
    run_start(3, 0);
    tick(2);
    cfg_write(0, 5, 5, 0, 0);
    wait_res(br + 2, 60);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("t5_abort_idle", 32'({busy, alu_valid, disp_valid}), 0);
    tick(10);
    check("t5_no_done", 32'(done_count - bd), 0);
    check("t5_xfers", 32'(xfer_count - bx), 2);
    push_op(0, 3, 4, 0, 0, 7, 0, 0, 0);
    run_start(1, 0);
    wait_done("t5_busy_write_dropped", 40);
    cfg_write(0, 5, 5, 0, 0);
    push_op(0, 5, 5, 0, 0, 10, 0, 0, 0);
    run_start(1, 0);
    wait_done("t5_idle_write_taken", 40);

    // Asynchronous reset in WAIT; table comes back as zeros.
    exp_xfer.push_back('{idx: 3'd0, x: 4'd5, y: 4'd5, m: 4'd0, cin: 1'b0});
    bx = xfer_count;
    run_start(3, 0);
    wait_xfer(bx + 1, 20);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_ctrl", 32'({alu_valid, busy, done, disp_valid, timeout_err}), 0);
    check("t6_rst_index", 32'(cur_index), 0);
    check("t6_rst_alu_ops", 32'({alu_x, alu_y, alu_m, alu_cin}), 0);
    check("t6_rst_disp", 32'({disp_x, disp_y, disp_m, disp_s, disp_cout}), 0);
    exp_xfer.delete();
    exp_res.delete();
    tick(3);
    reset = 1'b0;
    tick(1);
    push_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_op(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_start(2, 0);
    wait_done("t6_zero_run", 60);

    // Length 0 and 9 both run all eight entries.
    for (int i = 0; i < 8; i++) push_op(i, 0, 0, 0, 0, 0, 0, 0, 0);
    bx = xfer_count;
    run_start(0, 0);
    wait_done("t7_len0_done", 150);
    check("t7_len0_xfers", 32'(xfer_count - bx), 8);
    for (int i = 0; i < 8; i++) push_op(i, 0, 0, 0, 0, 0, 0, 0, 0);
    bx = xfer_count;
    run_start(9, 0);
    wait_done("t7_len9_done", 150);
    check("t7_len9_xfers", 32'(xfer_count - bx), 8);
    check("t7_queues_empty", 32'(exp_xfer.size() + exp_res.size()), 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Scheduler for the 4-bit ALU and 8-digit seven-segment display path.
- Holds an 8-entry table of ALU operations (X, Y, M, c_in) loaded from switches or a host.
- On start, issues each entry to the ALU over a valid/ready + done handshake, captures the result, and holds operands and result on display outputs for a dwell interval.
- Supports free-running or single-step mode; the display driver consumes the disp_* outputs.

Parameters:
DWELL_CYCLES, 100000000, clocks each result is held before the next issue (1 s at 100 MHz); minimum 1
TIMEOUT_CYCLES, 16, max clocks from handshake transfer to alu_done before flagging a timeout; minimum 1

Ports:
clock_100Mhz  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
cfg_we  in  1  write table entry (ignored while busy)
cfg_addr  in  3  table index to write
cfg_x, cfg_y, cfg_m  in  4 each  operand X, operand Y, mode/opcode
cfg_cin  in  1  carry-in for the entry
cfg_len  in  4  entries to run, 1..8; 0 and values >8 are treated as 8; sampled on start
start  in  1  single-cycle pulse; begins a run from entry 0 when idle
step_mode  in  1  1 = wait for step pulse after each dwell; sampled on start
step  in  1  single-cycle pulse; advances in STEP_WAIT
abort  in  1  single-cycle pulse; returns to IDLE
alu_x, alu_y, alu_m  out  4 each  operands to ALU
alu_cin  out  1  carry-in to ALU
alu_valid  out  1  request valid
alu_ready  in  1  ALU accepts request
alu_done  in  1  single-cycle result strobe
alu_s  in  4  ALU result
alu_cout  in  1  ALU carry/flag
disp_x, disp_y, disp_m, disp_s  out  4 each  values for display digits
disp_cout  out  1  captured carry
disp_valid  out  1  display data is current
cur_index  out  3  entry being processed
busy  out  1  high in any state except IDLE/DONE
done  out  1  single-cycle pulse when the run completes
timeout_err  out  1  sticky; set on timeout; cleared by start or reset

Behaviour:
- Reset values: all outputs 0; table entries 0; state IDLE.
- Table: on cfg_we with busy=0, entry[cfg_addr] <= {cfg_x, cfg_y, cfg_m, cfg_cin} at the clock edge; readable on the next cycle. Writes while busy are dropped.
- States: IDLE, ISSUE, WAIT, DWELL, STEP_WAIT, DONE.
- IDLE: on start, latch len (normalised 1..8) and step_mode, set index=0, clear timeout_err and disp_valid, go to ISSUE next cycle.
- ISSUE:
  - alu_valid=1; alu_* reflect entry[index] and are held stable while alu_valid=1 and alu_ready=0.
  - Transfer occurs on a cycle with alu_valid && alu_ready; the next state is WAIT and alu_valid drops the following cycle.
- WAIT:
  - Timeout counter starts at 0 the cycle after transfer.
  - On alu_done, capture alu_s/alu_cout into disp_s/disp_cout, copy the entry operands into disp_x/y/m, set disp_valid=1, go to DWELL.
  - Timeout: if the counter reaches TIMEOUT_CYCLES without alu_done, set timeout_err and disp_s=0, disp_cout=0, disp_valid=1, then go to DWELL so the run continues.
  - alu_done in ISSUE, DWELL or IDLE is ignored.
- DWELL:
  - Counter runs DWELL_CYCLES clocks, then:
    - step_mode=1: go to STEP_WAIT.
    - step_mode=0 and index==len-1: go to DONE.
    - step_mode=0 otherwise: index+1, go to ISSUE.
- STEP_WAIT: on step, apply the same index/len decision as DWELL expiry. Step pulses in other states are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. disp_* and disp_valid are retained until the next start.
- abort (any state except IDLE): next state IDLE; alu_valid drops next cycle; disp_valid cleared; no done pulse. abort has priority over all other events in the same cycle.
- start while busy is ignored. start and abort in the same cycle while IDLE: start is taken.
- Asynchronous reset mid-run forces reset values immediately, including alu_valid=0.
- Counters: dwell counter is 27 bits, timeout counter is 8 bits. Both clear on every state entry; no wrap inside a state.
- cur_index mirrors index and wraps only via restart, never past len-1.

Test Plan:
- Load entries 0..2 = (3,4,M=0,0),(9,8,M=1,1),(15,1,M=2,0), len=3, DWELL_CYCLES=4, ALU model ready=1, done 2 clocks after transfer.
  - Expected: three transfers; disp_s matches the model each time; done pulses once; index sequence 0,1,2; busy low after DONE.
- ALU ready held low 5 cycles on entry 0.
  - Expected: alu_valid high for 6 cycles with alu_x/y/m constant; exactly one transfer.
- ALU never asserts done on entry 1, TIMEOUT_CYCLES=16.
  - Expected: timeout_err set 16 cycles after transfer; disp_s=0; run continues to entry 2; timeout_err stays set until the next start.
- step_mode=1, len=2.
  - Expected: STEP_WAIT after each dwell; without step the sequencer holds indefinitely; two step pulses produce done.
- abort during DWELL of entry 1.
  - Expected: IDLE next cycle; disp_valid=0; no done. A cfg_we during the run is dropped; the same cfg_we after abort takes effect.
- reset asserted mid-WAIT.
  - Expected: all outputs 0 asynchronously; table cleared; the next start runs entries of zeros.
